// File: rtl/i2c_ccd_pkg.sv
// ---------------------------------------------------------------------------
// i2c_ccd_pkg
// Shared definitions for the CCD configuration-port I2C responder: the
// responder state encoding, the default sensor bus address and the byte/word
// widths used by both the configuration master and this responder.
// ---------------------------------------------------------------------------
package i2c_ccd_pkg;

   localparam int unsigned BYTE_W = 8;
   localparam int unsigned WORD_W = 16;

   // 7-bit target address: 8'hBA on the wire for writes, 8'hBB for reads.
   localparam logic [6:0] DEFAULT_SLAVE_ADDR = 7'h5D;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_REG,
      ST_REG_ACK,
      ST_WR_HI,
      ST_WR_HI_ACK,
      ST_WR_LO,
      ST_WR_LO_ACK,
      ST_RD_HI,
      ST_RD_HI_ACK,
      ST_RD_LO,
      ST_RD_LO_ACK,
      ST_IGNORE
   } state_e;

   // ACK state that follows a byte this responder receives.
   function automatic state_e ack_state(input state_e s);
      case (s)
         ST_ADDR:  ack_state = ST_ADDR_ACK;
         ST_REG:   ack_state = ST_REG_ACK;
         ST_WR_HI: ack_state = ST_WR_HI_ACK;
         default:  ack_state = ST_WR_LO_ACK;
      endcase
   endfunction

endpackage

// File: rtl/i2c_line_filter.sv
// ---------------------------------------------------------------------------
// i2c_line_filter
// Conditions one I2C line: 2-FF synchronizer followed by a persistence filter
// that only moves the filtered level after FILTER_LEN consecutive samples
// disagree with it. Shorter pulses are swallowed.
//   iCLK, iRST_N  system clock, asynchronous active-low reset
//   line_i        raw bus pin (idle high)
//   level_o       filtered level
//   rise_o/fall_o one-cycle pulses, coincident with the level_o change
// ---------------------------------------------------------------------------
module i2c_line_filter #(
   parameter int unsigned FILTER_LEN = 3
) (
   input  logic iCLK,
   input  logic iRST_N,
   input  logic line_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic       sync1_q, sync2_q, level_q, rise_q, fall_q;
   logic [3:0] cnt_q;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of the others, independent of process order.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         level_q <= 1'b1;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= line_i;
         sync2_q <= sync1_q;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
         if (sync2_q == level_q) begin
            cnt_q <= '0;
         end else if (cnt_q == 4'(FILTER_LEN - 1)) begin
            // FILTER_LEN-th consecutive disagreeing sample: accept it.
            level_q <= sync2_q;
            rise_q  <= sync2_q;
            fall_q  <= ~sync2_q;
            cnt_q   <= '0;
         end else begin
            cnt_q <= cnt_q + 4'd1;
         end
      end
   end

   assign level_o = level_q;
   assign rise_o  = rise_q;
   assign fall_o  = fall_q;

endmodule

// File: rtl/i2c_ccd_responder.sv
// ---------------------------------------------------------------------------
// i2c_ccd_responder
// I2C target emulating the CMOS sensor configuration port. Writes are
// [addr W] [reg] [data hi] [data lo] ...; each completed 16-bit word is
// presented as a one-cycle strobe and the register pointer auto-increments.
// Reads return iRD_DATA for the current pointer, MSB first.
//   iCLK, iRST_N        system clock (>= 50x SCL), async active-low reset
//   I2C_SCLK            bus clock (never stretched)
//   I2C_SDAT            open-drain data, only ever pulled low
//   oWR_ADDR/oWR_DATA   pointer and data of the last completed write
//   oWR_STB             one-cycle pulse per completed word
//   oRD_ADDR, iRD_DATA  current pointer and the read data it selects
//   oBUSY               address-matched transaction in progress
// ---------------------------------------------------------------------------
module i2c_ccd_responder
   import i2c_ccd_pkg::*;
#(
   parameter logic [6:0]  SLAVE_ADDR = DEFAULT_SLAVE_ADDR,
   parameter int unsigned FILTER_LEN = 3
) (
   input  logic              iCLK,
   input  logic              iRST_N,
   input  logic              I2C_SCLK,
   inout  wire               I2C_SDAT,
   output logic [BYTE_W-1:0] oWR_ADDR,
   output logic [WORD_W-1:0] oWR_DATA,
   output logic              oWR_STB,
   output logic [BYTE_W-1:0] oRD_ADDR,
   input  logic [WORD_W-1:0] iRD_DATA,
   output logic              oBUSY
);

   logic scl_lvl, scl_rise, scl_fall, sda_lvl, sda_rise, sda_fall;

   i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
      .iCLK(iCLK), .iRST_N(iRST_N), .line_i(I2C_SCLK),
      .level_o(scl_lvl), .rise_o(scl_rise), .fall_o(scl_fall));

   i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
      .iCLK(iCLK), .iRST_N(iRST_N), .line_i(I2C_SDAT),
      .level_o(sda_lvl), .rise_o(sda_rise), .fall_o(sda_fall));

   logic start_evt, stop_evt;
   assign start_evt = sda_fall & scl_lvl;
   assign stop_evt  = sda_rise & scl_lvl;

   state_e              state_q, state_d;
   logic [3:0]          bit_cnt_q, bit_cnt_d;
   logic [BYTE_W-1:0]   shift_q, shift_d, hold_q, hold_d, ptr_q, ptr_d;
   logic [BYTE_W-1:0]   wr_addr_q, wr_addr_d, rx_byte;
   logic [WORD_W-1:0]   wr_data_q, wr_data_d, rd_shift_q, rd_shift_d;
   logic                sda_oe_q, sda_oe_d, mack_q, mack_d;
   logic                busy_q, busy_d, wr_stb_q, wr_stb_d;

   always_comb begin
      // NOTE: every combinational output gets its hold value first, so no
      // path through the case statement can leave one unassigned (no latch).
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      hold_d     = hold_q;
      ptr_d      = ptr_q;
      rd_shift_d = rd_shift_q;
      sda_oe_d   = sda_oe_q;
      mack_d     = mack_q;
      busy_d     = busy_q;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      wr_stb_d   = 1'b0;
      rx_byte    = {shift_q[6:0], sda_lvl};

      if (stop_evt) begin
         state_d  = ST_IDLE;
         sda_oe_d = 1'b0;
         busy_d   = 1'b0;
      end else if (start_evt) begin
         state_d   = ST_ADDR;
         bit_cnt_d = '0;
         sda_oe_d  = 1'b0;
      end else begin
         case (state_q)
            ST_ADDR, ST_REG, ST_WR_HI, ST_WR_LO: begin
               if (scl_rise && bit_cnt_q != 4'd8) begin
                  shift_d   = rx_byte;
                  bit_cnt_d = bit_cnt_q + 4'd1;
                  if (bit_cnt_q == 4'd7) begin
                     if (state_q == ST_REG)   ptr_d  = rx_byte;
                     if (state_q == ST_WR_HI) hold_d = rx_byte;
                     if (state_q == ST_WR_LO) begin
                        wr_addr_d = ptr_q;
                        wr_data_d = {hold_q, rx_byte};
                        wr_stb_d  = 1'b1;
                        ptr_d     = ptr_q + 8'd1;
                     end
                  end
               end
               if (scl_fall && bit_cnt_q == 4'd8) begin
                  bit_cnt_d = '0;
                  if (state_q == ST_ADDR && shift_q[7:1] != SLAVE_ADDR) begin
                     state_d = ST_IGNORE;
                  end else begin
                     state_d  = ack_state(state_q);
                     sda_oe_d = 1'b1;
                     if (state_q == ST_ADDR) busy_d = 1'b1;
                  end
               end
            end
            ST_ADDR_ACK, ST_REG_ACK, ST_WR_HI_ACK, ST_WR_LO_ACK: begin
               if (scl_fall) begin
                  sda_oe_d = 1'b0;
                  if (state_q == ST_ADDR_ACK && shift_q[0]) begin
                     state_d    = ST_RD_HI;
                     rd_shift_d = iRD_DATA;
                     sda_oe_d   = ~iRD_DATA[15];
                  end else if (state_q == ST_ADDR_ACK) begin
                     state_d = ST_REG;
                  end else if (state_q == ST_WR_HI_ACK) begin
                     state_d = ST_WR_LO;
                  end else begin
                     state_d = ST_WR_HI;
                  end
               end
            end
            ST_RD_HI, ST_RD_LO: begin
               if (scl_rise) bit_cnt_d = bit_cnt_q + 4'd1;
               if (scl_fall) begin
                  if (bit_cnt_q == 4'd8) begin
                     bit_cnt_d = '0;
                     sda_oe_d  = 1'b0;
                     state_d   = (state_q == ST_RD_HI) ? ST_RD_HI_ACK : ST_RD_LO_ACK;
                  end else begin
                     // Rotate rather than shift so the register stays fully used.
                     rd_shift_d = {rd_shift_q[14:0], rd_shift_q[15]};
                     sda_oe_d   = ~rd_shift_q[14];
                  end
               end
            end
            ST_RD_HI_ACK: begin
               if (scl_fall) begin
                  state_d    = ST_RD_LO;
                  rd_shift_d = {rd_shift_q[14:0], rd_shift_q[15]};
                  sda_oe_d   = ~rd_shift_q[14];
               end
            end
            ST_RD_LO_ACK: begin
               // Pointer advances on the ACK rise so oRD_ADDR (and the
               // iRD_DATA it selects) settles before the reload on the fall.
               if (scl_rise) begin
                  mack_d = ~sda_lvl;
                  if (!sda_lvl) ptr_d = ptr_q + 8'd1;
               end
               if (scl_fall) begin
                  if (mack_q) begin
                     state_d    = ST_RD_HI;
                     rd_shift_d = iRD_DATA;
                     sda_oe_d   = ~iRD_DATA[15];
                  end else begin
                     state_d = ST_IGNORE;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Async reset clears sda_oe_q immediately, releasing the bus mid-ACK.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state_q    <= ST_IDLE;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         hold_q     <= '0;
         ptr_q      <= '0;
         rd_shift_q <= '0;
         sda_oe_q   <= 1'b0;
         mack_q     <= 1'b0;
         busy_q     <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         wr_stb_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         hold_q     <= hold_d;
         ptr_q      <= ptr_d;
         rd_shift_q <= rd_shift_d;
         sda_oe_q   <= sda_oe_d;
         mack_q     <= mack_d;
         busy_q     <= busy_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         wr_stb_q   <= wr_stb_d;
      end
   end

   assign I2C_SDAT = sda_oe_q ? 1'b0 : 1'bz;
   assign oWR_ADDR = wr_addr_q;
   assign oWR_DATA = wr_data_q;
   assign oWR_STB  = wr_stb_q;
   assign oRD_ADDR = ptr_q;
   assign oBUSY    = busy_q;

endmodule

// File: tb/tb_i2c_ccd_responder.sv
// ---------------------------------------------------------------------------
// tb_i2c_ccd_responder
// Bit-banged I2C master driving the responder, with a transaction-level model
// of the register pointer, expected write strobes and read data.
// ---------------------------------------------------------------------------
module tb_i2c_ccd_responder;

   localparam int QTR = 13;  // quarter SCL period in iCLK cycles

   logic        iCLK = 1'b0;
   logic        iRST_N = 1'b0;
   logic        scl = 1'b1;
   logic        m_sda_low = 1'b0;
   wire         sda_bus;
   logic [7:0]  wr_addr, rd_addr;
   logic [15:0] wr_data, rd_data;
   logic        wr_stb, busy;

   logic [15:0] rd_mem [256];
   logic [7:0]  tx_q [$];
   logic [23:0] stb_q [$];
   logic [23:0] exp_q [$];
   logic [7:0]  model_ptr = 8'h00;
   int          glitch_byte = -1;
   int          glitch_bit = -1;
   int          pass_cnt = 0;
   int          total_cnt = 0;
   int          stb_run = 0;
   bit          stb_wide = 1'b0;
   bit          dut_pulled = 1'b0;
   bit          busy_seen = 1'b0;

   always #10 iCLK = ~iCLK;

   pullup (sda_bus);
   assign sda_bus = m_sda_low ? 1'b0 : 1'bz;
   assign rd_data = rd_mem[rd_addr];

   i2c_ccd_responder #(.SLAVE_ADDR(7'h5D), .FILTER_LEN(3)) dut (
      .iCLK(iCLK), .iRST_N(iRST_N), .I2C_SCLK(scl), .I2C_SDAT(sda_bus),
      .oWR_ADDR(wr_addr), .oWR_DATA(wr_data), .oWR_STB(wr_stb),
      .oRD_ADDR(rd_addr), .iRD_DATA(rd_data), .oBUSY(busy));

   always @(negedge iCLK) begin
      if (wr_stb === 1'b1) begin
         stb_q.push_back({wr_addr, wr_data});
         stb_run = stb_run + 1;
         if (stb_run > 1) stb_wide = 1'b1;
      end else begin
         stb_run = 0;
      end
      if (!m_sda_low && sda_bus === 1'b0) dut_pulled = 1'b1;
      if (busy === 1'b1) busy_seen = 1'b1;
   end

   initial begin
      #1_800_000;
      $display("FAIL watchdog: simulation still running, want finished");
      $fatal(1);
   end

   task automatic clk_wait(input int n);
      repeat (n) @(negedge iCLK);
   endtask

   // One SCL period; entered and left with SCL low. Optional short SCL glitch.
   task automatic bit_out(input bit b, input bit glitch, output bit sampled);
      clk_wait(QTR);
      m_sda_low = ~b;
      clk_wait(QTR);
      scl = 1'b1;
      if (glitch) begin
         clk_wait(8); scl = 1'b0; clk_wait(2); scl = 1'b1; clk_wait(QTR - 10);
      end else begin
         clk_wait(QTR);
      end
      sampled = sda_bus;
      clk_wait(QTR);
      scl = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gbit, output bit ack);
      bit s;
      for (int i = 7; i >= 0; i--) bit_out(b[i], gbit == i, s);
      bit_out(1'b1, 1'b0, s);
      ack = ~s;
   endtask

   task automatic recv_byte(input bit mack, output logic [7:0] b);
      bit s;
      for (int i = 7; i >= 0; i--) begin
         bit_out(1'b1, 1'b0, s);
         b[i] = s;
      end
      bit_out(~mack, 1'b0, s);
   endtask

   task automatic i2c_start();
      if (!scl) begin
         clk_wait(QTR); m_sda_low = 1'b0; clk_wait(QTR); scl = 1'b1; clk_wait(QTR);
      end
      m_sda_low = 1'b1;
      clk_wait(QTR);
      scl = 1'b0;
   endtask

   task automatic i2c_stop();
      clk_wait(QTR); m_sda_low = 1'b1; clk_wait(QTR); scl = 1'b1;
      clk_wait(QTR); m_sda_low = 1'b0; clk_wait(2 * QTR);
   endtask

   task automatic send_bytes(output int n_ack);
      bit a;
      n_ack = 0;
      i2c_start();
      foreach (tx_q[i]) begin
         send_byte(tx_q[i], (i == glitch_byte) ? glitch_bit : -1, a);
         n_ack += int'(a);
      end
   endtask

   // Reference: byte 1 sets the pointer, each complete pair after it is one
   // word written at the pointer, which then advances (mod 256).
   task automatic model_write();
      if (tx_q.size() >= 2) model_ptr = tx_q[1];
      for (int i = 2; i + 1 < tx_q.size(); i += 2) begin
         exp_q.push_back({model_ptr, tx_q[i], tx_q[i+1]});
         model_ptr = model_ptr + 8'd1;
      end
   endtask

   task automatic test_reset();
      iRST_N = 1'b0; clk_wait(5); iRST_N = 1'b1; clk_wait(10);
      total_cnt++; if (wr_stb !== 1'b0) $display("FAIL reset_stb: got %b want 0", wr_stb); else pass_cnt++;
      total_cnt++; if (wr_addr !== 8'h00) $display("FAIL reset_wr_addr: got %h want 00", wr_addr); else pass_cnt++;
      total_cnt++; if (wr_data !== 16'h0000) $display("FAIL reset_wr_data: got %h want 0000", wr_data); else pass_cnt++;
      total_cnt++; if (rd_addr !== 8'h00) $display("FAIL reset_rd_addr: got %h want 00", rd_addr); else pass_cnt++;
      total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
      total_cnt++; if (sda_bus !== 1'b1) $display("FAIL reset_sda: got %b want 1", sda_bus); else pass_cnt++;
   endtask

   task automatic test_write();
      int n_ack;
      stb_q.delete(); stb_wide = 1'b0;
      tx_q = {8'hBA, 8'h09, 8'h07, 8'hC0};
      send_bytes(n_ack);
      total_cnt++; if (n_ack != 4) $display("FAIL write_acks: got %0d want 4", n_ack); else pass_cnt++;
      total_cnt++; if (busy !== 1'b1) $display("FAIL write_busy_hi: got %b want 1", busy); else pass_cnt++;
      i2c_stop();
      total_cnt++; if (busy !== 1'b0) $display("FAIL write_busy_lo: got %b want 0", busy); else pass_cnt++;
      total_cnt++; if (stb_q.size() != 1) $display("FAIL write_stb_count: got %0d want 1", stb_q.size()); else pass_cnt++;
      if (stb_q.size() > 0) begin
         total_cnt++; if (stb_q[0] !== 24'h0907C0) $display("FAIL write_word: got %h want 0907c0", stb_q[0]); else pass_cnt++;
      end
      total_cnt++; if (stb_wide) $display("FAIL write_stb_width: got >1 cycle want 1 cycle"); else pass_cnt++;
      total_cnt++; if (rd_addr !== 8'h0A) $display("FAIL write_ptr: got %h want 0a", rd_addr); else pass_cnt++;
      model_ptr = 8'h0A;
   endtask

   task automatic test_mismatch();
      int n_ack;
      stb_q.delete(); dut_pulled = 1'b0; busy_seen = 1'b0;
      tx_q = {8'h90, 8'h55};
      send_bytes(n_ack);
      i2c_stop();
      total_cnt++; if (n_ack != 0) $display("FAIL mismatch_acks: got %0d want 0", n_ack); else pass_cnt++;
      total_cnt++; if (dut_pulled) $display("FAIL mismatch_sda: got driven want released"); else pass_cnt++;
      total_cnt++; if (stb_q.size() != 0) $display("FAIL mismatch_stb: got %0d want 0", stb_q.size()); else pass_cnt++;
      total_cnt++; if (busy_seen) $display("FAIL mismatch_busy: got 1 want 0"); else pass_cnt++;
   endtask

   task automatic test_read();
      int n_ack; bit a, s; logic [7:0] hi, lo;
      rd_mem[8'h2B] = 16'h000B;
      tx_q = {8'hBA, 8'h2B};
      send_bytes(n_ack);
      i2c_start();
      send_byte(8'hBB, -1, a);
      total_cnt++; if (n_ack != 2 || !a) $display("FAIL read_acks: got %0d/%b want 2/1", n_ack, a); else pass_cnt++;
      recv_byte(1'b1, hi); recv_byte(1'b1, lo);
      total_cnt++; if ({hi, lo} !== 16'h000B) $display("FAIL read_word0: got %h want 000b", {hi, lo}); else pass_cnt++;
      recv_byte(1'b1, hi); recv_byte(1'b0, lo);
      total_cnt++; if ({hi, lo} !== rd_mem[8'h2C]) $display("FAIL read_word1: got %h want %h", {hi, lo}, rd_mem[8'h2C]); else pass_cnt++;
      total_cnt++; if (rd_addr !== 8'h2C) $display("FAIL read_ptr: got %h want 2c", rd_addr); else pass_cnt++;
      dut_pulled = 1'b0;
      bit_out(1'b1, 1'b0, s);
      total_cnt++; if (dut_pulled || s !== 1'b1) $display("FAIL read_nack_release: got driven want released"); else pass_cnt++;
      i2c_stop();
      total_cnt++; if (busy !== 1'b0) $display("FAIL read_busy: got %b want 0", busy); else pass_cnt++;
      model_ptr = 8'h2C;
   endtask

   task automatic test_abort_burst();
      int n_ack;
      stb_q.delete();
      tx_q = {8'hBA, 8'h20, 8'hC0};
      send_bytes(n_ack); i2c_stop();
      total_cnt++; if (stb_q.size() != 0) $display("FAIL abort_stb: got %0d want 0", stb_q.size()); else pass_cnt++;
      total_cnt++; if (rd_addr !== 8'h20) $display("FAIL abort_ptr: got %h want 20", rd_addr); else pass_cnt++;
      stb_q.delete();
      tx_q = {8'hBA, 8'hFF, 8'h11, 8'h11, 8'h22, 8'h22};
      send_bytes(n_ack); i2c_stop();
      total_cnt++; if (n_ack != 6) $display("FAIL burst_acks: got %0d want 6", n_ack); else pass_cnt++;
      total_cnt++; if (stb_q.size() != 2) $display("FAIL burst_stb_count: got %0d want 2", stb_q.size()); else pass_cnt++;
      if (stb_q.size() == 2) begin
         total_cnt++; if (stb_q[0] !== 24'hFF1111) $display("FAIL burst_word0: got %h want ff1111", stb_q[0]); else pass_cnt++;
         total_cnt++; if (stb_q[1] !== 24'h002222) $display("FAIL burst_word1: got %h want 002222", stb_q[1]); else pass_cnt++;
      end
      total_cnt++; if (rd_addr !== 8'h01) $display("FAIL burst_ptr: got %h want 01", rd_addr); else pass_cnt++;
      model_ptr = 8'h01;
   endtask

   task automatic test_glitch();
      int n_ack;
      stb_q.delete();
      tx_q = {8'hBA, 8'h33, 8'hA5, 8'h5A};
      glitch_byte = 2; glitch_bit = 4;
      send_bytes(n_ack); i2c_stop();
      glitch_byte = -1; glitch_bit = -1;
      total_cnt++; if (n_ack != 4) $display("FAIL glitch_acks: got %0d want 4", n_ack); else pass_cnt++;
      total_cnt++; if (stb_q.size() != 1) $display("FAIL glitch_stb_count: got %0d want 1", stb_q.size()); else pass_cnt++;
      if (stb_q.size() > 0) begin
         total_cnt++; if (stb_q[0] !== 24'h33A55A) $display("FAIL glitch_word: got %h want 33a55a", stb_q[0]); else pass_cnt++;
      end
      model_ptr = 8'h34;
   endtask

   task automatic test_reset_mid_ack();
      bit a, s, seen; int n_ack; logic [7:0] b;
      b = 8'h05; seen = 1'b0;
      i2c_start();
      send_byte(8'hBA, -1, a);
      for (int i = 7; i >= 0; i--) bit_out(b[i], 1'b0, s);
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge iCLK);
         if (sda_bus === 1'b0) seen = 1'b1;
      end
      total_cnt++; if (!seen) $display("FAIL rst_ack_driven: got released want pulled low"); else pass_cnt++;
      total_cnt++; if (busy !== 1'b1) $display("FAIL rst_busy_before: got %b want 1", busy); else pass_cnt++;
      @(posedge iCLK); #2;
      iRST_N = 1'b0;
      #1;
      total_cnt++; if (sda_bus !== 1'b1) $display("FAIL rst_sda_release: got %b want 1", sda_bus); else pass_cnt++;
      total_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy_drop: got %b want 0", busy); else pass_cnt++;
      clk_wait(3); iRST_N = 1'b1;
      bit_out(1'b1, 1'b0, s);
      i2c_stop();
      stb_q.delete();
      tx_q = {8'hBA, 8'h05, 8'h00, 8'h00};
      send_bytes(n_ack); i2c_stop();
      total_cnt++; if (n_ack != 4) $display("FAIL rst_next_acks: got %0d want 4", n_ack); else pass_cnt++;
      total_cnt++; if (stb_q.size() != 1 || stb_q[0] !== 24'h050000)
         $display("FAIL rst_next_word: got n=%0d w=%h want n=1 w=050000", stb_q.size(), (stb_q.size() > 0) ? stb_q[0] : 24'h0);
      else pass_cnt++;
      model_ptr = 8'h06;
   endtask

   task automatic test_random();
      logic [7:0] p, hi, lo; int nw, n_ack; bit partial, a;
      for (int t = 0; t < 4; t++) begin
         p = 8'($urandom); nw = $urandom_range(1, 2); partial = 1'($urandom);
         tx_q = {8'hBA, p};
         for (int w = 0; w < 2 * nw; w++) tx_q.push_back(8'($urandom));
         if (partial) tx_q.push_back(8'($urandom));
         exp_q.delete(); stb_q.delete();
         model_write();
         send_bytes(n_ack); i2c_stop();
         total_cnt++; if (n_ack != tx_q.size()) $display("FAIL rnd%0d_acks: got %0d want %0d", t, n_ack, tx_q.size()); else pass_cnt++;
         total_cnt++; if (stb_q.size() != exp_q.size()) $display("FAIL rnd%0d_stb_count: got %0d want %0d", t, stb_q.size(), exp_q.size()); else pass_cnt++;
         for (int i = 0; i < exp_q.size() && i < stb_q.size(); i++) begin
            total_cnt++; if (stb_q[i] !== exp_q[i]) $display("FAIL rnd%0d_word%0d: got %h want %h", t, i, stb_q[i], exp_q[i]); else pass_cnt++;
         end
         total_cnt++; if (rd_addr !== model_ptr) $display("FAIL rnd%0d_wr_ptr: got %h want %h", t, rd_addr, model_ptr); else pass_cnt++;

         p = 8'($urandom); nw = $urandom_range(1, 2);
         tx_q = {8'hBA, p};
         model_write();
         send_bytes(n_ack);
         i2c_start();
         send_byte(8'hBB, -1, a);
         total_cnt++; if (n_ack != 2 || !a) $display("FAIL rnd%0d_rd_acks: got %0d/%b want 2/1", t, n_ack, a); else pass_cnt++;
         for (int w = 0; w < nw; w++) begin
            recv_byte(1'b1, hi);
            recv_byte(w != nw - 1, lo);
            total_cnt++; if ({hi, lo} !== rd_mem[model_ptr])
               $display("FAIL rnd%0d_rd%0d: got %h want %h", t, w, {hi, lo}, rd_mem[model_ptr]);
            else pass_cnt++;
            if (w != nw - 1) model_ptr = model_ptr + 8'd1;
         end
         i2c_stop();
         total_cnt++; if (rd_addr !== model_ptr) $display("FAIL rnd%0d_rd_ptr: got %h want %h", t, rd_addr, model_ptr); else pass_cnt++;
      end
   endtask

   initial begin
      foreach (rd_mem[i]) rd_mem[i] = 16'($urandom);
      test_reset();
      test_write();
      test_mismatch();
      test_read();
      test_abort_burst();
      test_glitch();
      test_reset_mid_ack();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
